rx_link_arbiter: RTL and testbench

Parametrised multi-channel receive front end for the chip-to-PC path. Terminates CH_NUM asynchronous two-phase (toggle) REQ/ACK receive links, buffers one word per channel, merges them round-robin onto a single AXI4-Stream master toward the DMA, and tags each beat with its source channel. Packets are framed with TLAST by beat count or by an idle timeout.

---
 rtl/rx_link_pkg.sv | 20 ++
 rtl/rx_link_if.sv | 50 +++++
 rtl/rx_link_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rx_link_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_link_pkg.sv
// Shared constants and width helpers for the receive-link arbiter slice.
package rx_link_pkg;

    localparam int DIR_E = 0;
    localparam int DIR_S = 1;
    localparam int DIR_W = 2;
    localparam int DIR_N = 3;

    // tkeep bit value used to mark a null (timeout) beat
    localparam logic NULL_KEEP_BIT = 1'b0;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_link_if.sv
// One toggle REQ/ACK receive link: request synchroniser, one-word buffer, ack toggle.
module rx_link_if #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    input  logic              take,
    output logic              ack,
    output logic              full,
    output logic [DATA_W-1:0] word
);

    logic              meta_r;
    logic              req_s_r;
    logic              ack_r;
    logic              full_r;
    logic [DATA_W-1:0] word_r;
    logic              capture_s;

    assign capture_s = (req_s_r != ack_r) && en && !full_r;

    // synchroniser, capture-and-acknowledge, buffer release on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r  <= 1'b0;
            req_s_r <= 1'b0;
            ack_r   <= 1'b0;
            full_r  <= 1'b0;
            word_r  <= {DATA_W{1'b0}};
        end else begin
            meta_r  <= req;
            req_s_r <= meta_r;
            if (capture_s) begin
                word_r <= data;
                full_r <= 1'b1;
                ack_r  <= ~ack_r;
            end else if (take) begin
                full_r <= 1'b0;
            end
        end
    end

    assign ack  = ack_r;
    assign full = full_r;
    assign word = word_r;

endmodule

// File: rtl/rx_link_arbiter.sv
// Multi-link receive front end: round-robin merge of link buffers onto one
// AXI4-Stream master with source tagging, beat-count and idle-timeout framing.
module rx_link_arbiter
    import rx_link_pkg::*;
#(
    parameter  int CH_NUM  = 4,
    parameter  int DATA_W  = 16,
    parameter  int PKT_LEN = 256,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = ch_w(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic [CH_NUM-1:0]        rx_req,
    input  logic [CH_NUM*DATA_W-1:0] rx_data,
    output logic [CH_NUM-1:0]        rx_ack,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [DATA_W/8-1:0]      m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [CH_W-1:0]          m_axis_tid,
    output logic                     rece_done,
    output logic [31:0]              rece_count
);

    localparam int   KEEP_W     = DATA_W / 8;
    localparam int   BEAT_W     = cnt_w(PKT_LEN);
    localparam int   IDLE_W     = cnt_w(TIMEOUT);
    localparam logic TIMEOUT_EN = (TIMEOUT > 0);

    logic [CH_NUM-1:0] full_s;
    logic [CH_NUM-1:0] take_s;
    logic [DATA_W-1:0] word_s [CH_NUM];

    logic [CH_W-1:0]   ptr_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic              tvalid_r;
    logic [DATA_W-1:0] tdata_r;
    logic [KEEP_W-1:0] tkeep_r;
    logic              tlast_r;
    logic [CH_W-1:0]   tid_r;
    logic              rece_done_r;
    logic [31:0]       rece_count_r;

    logic              can_load_s;
    logic              grant_vld_s;
    logic [CH_W-1:0]   grant_idx_s;
    int                cand_s;
    logic              hit_s;
    logic              load_data_s;
    logic              load_null_s;
    logic              last_beat_s;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_link
        rx_link_if #(.DATA_W(DATA_W)) u_link (
            .clk  (clk),
            .rst  (rst),
            .en   (ch_en[g]),
            .req  (rx_req[g]),
            .data (rx_data[g*DATA_W +: DATA_W]),
            .take (take_s[g]),
            .ack  (rx_ack[g]),
            .full (full_s[g]),
            .word (word_s[g])
        );
    end

    assign can_load_s  = !tvalid_r || m_axis_tready;
    assign load_data_s = grant_vld_s && can_load_s;
    assign load_null_s = TIMEOUT_EN && (idle_cnt_r == IDLE_W'(TIMEOUT)) && can_load_s && !grant_vld_s;
    assign last_beat_s = (beat_cnt_r == BEAT_W'(PKT_LEN - 1));

    // round-robin search starting at the channel after the previous grant
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {CH_W{1'b0}};
        cand_s      = 0;
        hit_s       = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            cand_s      = (int'(ptr_r) + i >= CH_NUM) ? int'(ptr_r) + i - CH_NUM : int'(ptr_r) + i;
            hit_s       = !grant_vld_s && full_s[cand_s];
            grant_idx_s = hit_s ? CH_W'(cand_s) : grant_idx_s;
            grant_vld_s = grant_vld_s || hit_s;
        end
    end

    // one-hot buffer release for the granted channel
    always_comb begin
        take_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            take_s[i] = load_data_s && (grant_idx_s == CH_W'(i));
        end
    end

    // output register: data beat, null beat, or drain on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {DATA_W{1'b0}};
            tkeep_r  <= {KEEP_W{1'b0}};
            tlast_r  <= 1'b0;
            tid_r    <= {CH_W{1'b0}};
        end else if (load_data_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= word_s[grant_idx_s];
            tkeep_r  <= {KEEP_W{1'b1}};
            tlast_r  <= last_beat_s;
            tid_r    <= grant_idx_s;
        end else if (load_null_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= {DATA_W{1'b0}};
            tkeep_r  <= {KEEP_W{NULL_KEEP_BIT}};
            tlast_r  <= 1'b1;
            tid_r    <= {CH_W{1'b0}};
        end else if (m_axis_tready) begin
            tvalid_r <= 1'b0;
        end
    end

    // framing counters and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= {CH_W{1'b0}};
            beat_cnt_r <= {BEAT_W{1'b0}};
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (load_data_s) begin
            ptr_r      <= (grant_idx_s == CH_W'(CH_NUM - 1)) ? {CH_W{1'b0}} : grant_idx_s + CH_W'(1'b1);
            beat_cnt_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_cnt_r + BEAT_W'(1'b1);
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (load_null_s) begin
            beat_cnt_r <= {BEAT_W{1'b0}};
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if ((beat_cnt_r != {BEAT_W{1'b0}}) && (idle_cnt_r != IDLE_W'(TIMEOUT))) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1'b1);
        end
    end

    // delivery statistics; null beats are not counted as data
    always_ff @(posedge clk) begin
        if (rst) begin
            rece_done_r  <= 1'b0;
            rece_count_r <= 32'd0;
        end else begin
            rece_done_r <= tvalid_r && m_axis_tready && tlast_r;
            if (tvalid_r && m_axis_tready && (tkeep_r != {KEEP_W{1'b0}})) begin
                rece_count_r <= rece_count_r + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tid    = tid_r;
    assign rece_done     = rece_done_r;
    assign rece_count    = rece_count_r;

endmodule

// File: tb/tb_rx_link_arbiter.sv
// Scoreboard bench for rx_link_arbiter: per-channel expected-word queues filled
// by the link senders, consumed by an independent stream monitor.
module tb_rx_link_arbiter;

    localparam int CH_NUM  = 4;
    localparam int DATA_W  = 16;
    localparam int PKT_LEN = 4;
    localparam int TIMEOUT = 16;
    localparam int CH_W    = 2;
    localparam int KEEP_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [CH_NUM-1:0]        ch_en;
    logic [CH_NUM-1:0]        rx_req;
    logic [CH_NUM*DATA_W-1:0] rx_data;
    logic [CH_NUM-1:0]        rx_ack;
    logic                     tready;
    logic                     tvalid;
    logic [DATA_W-1:0]        tdata;
    logic [KEEP_W-1:0]        tkeep;
    logic                     tlast;
    logic [CH_W-1:0]          tid;
    logic                     rece_done;
    logic [31:0]              rece_count;

    logic              req_arr  [CH_NUM];
    logic [DATA_W-1:0] data_arr [CH_NUM];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int null_exp = 0;
    int pkt_pos = 0;
    int exp_words = 0;
    int done_cnt = 0;
    int last_data_cyc = 0;
    int last_gap = 0;
    int tid3_cnt = 0;
    int e_thr [CH_NUM];
    logic [DATA_W-1:0] exp_q [CH_NUM][$];
    int obs_tid [$];
    int obs_cyc [$];

    rx_link_arbiter #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .rx_req(rx_req), .rx_data(rx_data),
        .rx_ack(rx_ack), .m_axis_tready(tready), .m_axis_tvalid(tvalid),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tid(tid), .rece_done(rece_done), .rece_count(rece_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        rx_req  = '0;
        rx_data = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            rx_req[i]                  = req_arr[i];
            rx_data[i*DATA_W +: DATA_W] = data_arr[i];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < CH_NUM; i++) begin
            if (exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // stream monitor / scoreboard
    initial forever begin
        logic [DATA_W-1:0] w;
        @(negedge clk);
        if (rst) begin
            pkt_pos = 0;
        end else begin
            if (rece_done) done_cnt++;
            if (tvalid && tready) begin
                if (tkeep == '0) begin
                    check("null_expected", 32'(null_exp > 0), 32'd1);
                    if (null_exp > 0) null_exp--;
                    check("null_tlast", 32'(tlast), 32'd1);
                    check("null_tdata", 32'(tdata), 32'd0);
                    check("null_tid", 32'(tid), 32'd0);
                    last_gap = cyc - last_data_cyc;
                    pkt_pos  = 0;
                end else begin
                    check("data_tkeep", 32'(tkeep), 32'h3);
                    if (exp_q[tid].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: tid %0d data 0x%0h, expected no beat", tid, tdata);
                    end else begin
                        w = exp_q[tid].pop_front();
                        check("data_tdata", 32'(tdata), 32'(w));
                    end
                    pkt_pos++;
                    check("data_tlast", 32'(tlast), 32'(pkt_pos == PKT_LEN));
                    if (pkt_pos == PKT_LEN) pkt_pos = 0;
                    last_data_cyc = cyc;
                    obs_tid.push_back(int'(tid));
                    obs_cyc.push_back(cyc);
                    if (!ch_en[3] && tid == 2'd3) tid3_cnt++;
                end
            end
        end
    end

    // one toggle transfer on a link; edges = clock edges until the ack toggles
    task automatic send(input int ch, input logic [DATA_W-1:0] w, output int edges);
        @(negedge clk);
        data_arr[ch] = w;
        req_arr[ch]  = ~req_arr[ch];
        exp_q[ch].push_back(w);
        exp_words++;
        edges = 0;
        while (rx_ack[ch] !== req_arr[ch] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (rx_ack[ch] !== req_arr[ch]) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: ch %0d ack %0b, expected %0b", ch, rx_ack[ch], req_arr[ch]);
        end
    endtask

    task automatic send_seq(input int ch, input logic [DATA_W-1:0] base, input int n);
        int e;
        for (int k = 0; k < n; k++) send(ch, base + DATA_W'(k), e);
    endtask

    task automatic drain(input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            done = queues_empty() && !tvalid && (null_exp == 0);
        end
        check(name, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(tdata), 32'd0);
        check({tag, "_tkeep"}, 32'(tkeep), 32'd0);
        check({tag, "_tlast"}, 32'(tlast), 32'd0);
        check({tag, "_tid"}, 32'(tid), 32'd0);
        check({tag, "_rx_ack"}, 32'(rx_ack), 32'd0);
        check({tag, "_rece_done"}, 32'(rece_done), 32'd0);
        check({tag, "_rece_count"}, rece_count, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int acks;
        int d0;
        logic [CH_NUM-1:0] prev;
        logic [DATA_W-1:0] hd;
        bit held;
        logic a3;

        rst    = 1'b1;
        ch_en  = 4'hF;
        tready = 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
            req_arr[i]  = 1'b0;
            data_arr[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // all four links at once: strict 0,1,2,3 order, back to back, two rounds
        obs_tid.delete();
        obs_cyc.delete();
        fork
            send_seq(0, 16'h0010, 2);
            send_seq(1, 16'h0020, 2);
            send_seq(2, 16'h0030, 2);
            send_seq(3, 16'h0040, 2);
        join
        drain("drain_rr");
        check("rr_beats", 32'(obs_tid.size()), 32'd8);
        if (obs_tid.size() == 8) begin
            for (int k = 0; k < 8; k++) check("rr_order_tid", 32'(obs_tid[k]), 32'(k % 4));
            for (int k = 1; k < 8; k++) check("rr_back_to_back", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd1);
        end

        // single W link, words 1..8, ack three edges after each request toggle
        for (int k = 1; k <= 8; k++) begin
            send(2, DATA_W'(k), e);
            check("ack_latency", 32'(e), 32'd3);
        end
        drain("drain_w_link");

        // ten words: tlast on beats 4 and 8, remainder closed by a null beat
        d0 = done_cnt;
        send_seq(0, 16'h0100, 10);
        null_exp++;
        drain("drain_pkt");
        check("rece_done_pulses", 32'(done_cnt - d0), 32'd3);
        check("rece_count_pkt", rece_count, 32'(exp_words));

        // three words then silence: null beat 17 cycles after the last data beat
        send_seq(2, 16'h0200, 3);
        null_exp++;
        drain("drain_timeout");
        check("timeout_gap", 32'(last_gap), 32'd17);
        check("rece_count_timeout", rece_count, 32'(exp_words));

        // back-pressure: one word per buffer plus the output register get acked
        @(posedge clk);
        #2 tready = 1'b0;
        prev = rx_ack;
        acks = 0;
        held = 1'b0;
        hd   = '0;
        fork
            send_seq(0, 16'h0310, 3);
            send_seq(1, 16'h0320, 3);
            send_seq(2, 16'h0330, 3);
            send_seq(3, 16'h0340, 3);
        join_none
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acks += $countones(rx_ack ^ prev);
            prev = rx_ack;
            if (held) begin
                check("stall_tvalid_held", 32'(tvalid), 32'd1);
                check("stall_tdata_stable", 32'(tdata), 32'(hd));
            end else if (tvalid) begin
                held = 1'b1;
                hd   = tdata;
            end
        end
        check("stall_ack_count", 32'(acks), 32'd5);
        check("stall_output_loaded", 32'(held), 32'd1);
        @(posedge clk);
        #2 tready = 1'b1;
        wait fork;
        drain("drain_stall");
        check("rece_count_stall", rece_count, 32'(exp_words));

        // disabled N link: no ack, no beat; word delivered after re-enable
        @(posedge clk);
        #2 ch_en[3] = 1'b0;
        tid3_cnt = 0;
        a3 = req_arr[3];
        fork
            send(3, 16'h0400, e_thr[3]);
        join_none
        send_seq(1, 16'h0410, 4);
        repeat (4) @(negedge clk);
        check("disabled_ack_static", 32'(rx_ack[3]), 32'(a3));
        check("disabled_no_tid3", 32'(tid3_cnt), 32'd0);
        @(posedge clk);
        #2 ch_en[3] = 1'b1;
        wait fork;
        send_seq(3, 16'h0401, 3);
        drain("drain_enable");
        check("rece_count_enable", rece_count, 32'(exp_words));

        // reset in the middle of traffic drops buffered words
        fork
            send(0, 16'h0500, e_thr[0]);
            send(1, 16'h0501, e_thr[1]);
            send(2, 16'h0502, e_thr[2]);
            send(3, 16'h0503, e_thr[3]);
        join_none
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < CH_NUM; i++) req_arr[i] = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #2 rst = 1'b0;
        wait fork;
        for (int i = 0; i < CH_NUM; i++) exp_q[i].delete();
        exp_words = 0;
        null_exp  = 0;

        send(1, 16'h0555, e);
        check("post_reset_latency", 32'(e), 32'd3);
        null_exp++;
        drain("drain_post_reset");
        check("rece_count_post_reset", rece_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
